// File: rtl/hazard_unit.sv
// hazard_unit
//   Pipeline stall/flush controller that sits next to the forwarding unit in ID/EX.
//   - Load-use hazards that forwarding cannot cover: holds IF/ID and injects
//     LU_STALL bubbles into ID/EX.
//   - An outstanding data-memory access in MEM freezes the whole pipe.
//   - A taken branch/jump resolved in EX flushes the wrong-path IF/ID and ID/EX.
//   - Keeps a saturating count of IF-stall cycles and a sticky dmem-timeout flag.
//
// Handshake semantics: mem_req_i marks a dmem access in flight in MEM, and
//   mem_rsp_i marks its completion in the same cycle. A cycle with
//   mem_req_i=1 and mem_rsp_i=0 is a busy cycle and stalls the pipe. A cycle
//   with both high completes the access, and that cycle is not stalled.
//
// Ports
//   clk_i, rst_ni                     clock, async active-low reset
//   id_sel_rs1_i/_rs2_i, id_uses_*    source registers of the ID instruction
//   ex_sel_rd_i, ex_is_load_i         destination / load flag of the EX instruction
//   ex_redirect_i                     taken branch/jump resolved in EX
//   mem_req_i, mem_rsp_i              dmem access in flight / response
//   stall_if_o .. stall_mem_o         per-stage hold signals
//   flush_if_id_o, flush_id_ex_o      NOP injection into the pipeline registers
//   stall_cycles_o                    saturating count of cycles with stall_if_o=1
//   mem_err_o                         sticky dmem timeout flag
module hazard_unit #(
  parameter int LU_STALL    = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_sel_rs1_i,
  input  logic [4:0]       id_sel_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_sel_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_rsp_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             mem_err_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  // lu_cnt value of the last bubble cycle spent in LU_STALL_S
  localparam logic [1:0] LU_LAST = 2'(LU_STALL - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL_S = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  state_e             eff_state;
  logic [1:0]         lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               mem_err_q, mem_err_d;
  logic               mem_busy;
  logic               lu_hit;

  assign mem_busy = mem_req_i & ~mem_rsp_i;
  assign lu_hit   = ex_is_load_i & (ex_sel_rd_i != 5'd0) &
                    ((id_uses_rs1_i & (id_sel_rs1_i == ex_sel_rd_i)) |
                     (id_uses_rs2_i & (id_sel_rs2_i == ex_sel_rd_i)));

  // When MEM_WAIT is released, the cycle is handled as the state the freeze
  // interrupted. A saved lu_cnt means the freeze interrupted a load-use stall.
  // Otherwise it was RUN, and the re-presented load-use hit must still be
  // caught in the release cycle.
  always_comb begin
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = (lu_cnt_q != 2'd0) ? LU_STALL_S : RUN;
    end
  end

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    stall_if_o    = 1'b0;
    stall_id_o    = 1'b0;
    stall_ex_o    = 1'b0;
    stall_mem_o   = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;

    if (mem_busy) begin
      // Whole pipe frozen; redirect / load-use are re-presented after release.
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      state_d     = MEM_WAIT;
      if (state_q == MEM_WAIT) begin
        if (wait_cnt_q != {WAIT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (wait_cnt_d >= TIMEOUT_V) begin
          mem_err_d = 1'b1;
        end
      end
    end else begin
      wait_cnt_d = '0;
      state_d    = eff_state;
      if (ex_redirect_i) begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        state_d       = RUN;
        lu_cnt_d      = 2'd0;
      end else if (eff_state == LU_STALL_S) begin
        stall_if_o    = 1'b1;
        stall_id_o    = 1'b1;
        flush_id_ex_o = 1'b1;
        if (lu_cnt_q == LU_LAST) begin
          state_d  = RUN;
          lu_cnt_d = 2'd0;
        end else begin
          lu_cnt_d = lu_cnt_q + 2'd1;
        end
      end else if (lu_hit) begin
        stall_if_o    = 1'b1;
        stall_id_o    = 1'b1;
        flush_id_ex_o = 1'b1;
        // With a single-cycle stall the load leaves EX after this bubble,
        // so there is no need to leave RUN.
        if (LU_STALL > 1) begin
          state_d  = LU_STALL_S;
          lu_cnt_d = 2'd1;
        end
      end
    end

    if (!rst_ni) begin
      stall_if_o    = 1'b0;
      stall_id_o    = 1'b0;
      stall_ex_o    = 1'b0;
      stall_mem_o   = 1'b0;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      lu_cnt_q    <= 2'd0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lu_cnt_q   <= lu_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (stall_if_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign mem_err_o      = mem_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit. Instance A: LU_STALL=1, MEM_TIMEOUT=4, CNT_W=3.
// Instance B: LU_STALL=2, CNT_W=8. Each driven cycle pushes the expected
// {stalls, flushes, mem_err, stall_cycles} word. A monitor pops and compares
// that word on the following falling edge.
module tb_hazard_unit;

  localparam int W = 39;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_BUB  = 6'b110001;
  localparam logic [5:0] C_MEM  = 6'b111100;
  localparam logic [5:0] C_FL   = 6'b000011;
  localparam logic [5:0] C_RST  = 6'b000011;

  logic clk;
  logic [21:0] va, vb;

  logic       a_sif, a_sid, a_sex, a_smem, a_fif, a_fex, a_err;
  logic [2:0] a_cnt;
  logic       b_sif, b_sid, b_sex, b_smem, b_fif, b_fex, b_err;
  logic [7:0] b_cnt;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int checks;
  int errors;
  int na;
  int nb;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_unit #(.LU_STALL(1), .MEM_TIMEOUT(4), .CNT_W(3)) dut_a (
    .clk_i(clk), .rst_ni(va[21]),
    .id_sel_rs1_i(va[20:16]), .id_sel_rs2_i(va[15:11]),
    .id_uses_rs1_i(va[10]), .id_uses_rs2_i(va[9]),
    .ex_sel_rd_i(va[8:4]), .ex_is_load_i(va[3]),
    .ex_redirect_i(va[2]), .mem_req_i(va[1]), .mem_rsp_i(va[0]),
    .stall_if_o(a_sif), .stall_id_o(a_sid), .stall_ex_o(a_sex),
    .stall_mem_o(a_smem), .flush_if_id_o(a_fif), .flush_id_ex_o(a_fex),
    .stall_cycles_o(a_cnt), .mem_err_o(a_err)
  );

  hazard_unit #(.LU_STALL(2), .MEM_TIMEOUT(255), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_ni(vb[21]),
    .id_sel_rs1_i(vb[20:16]), .id_sel_rs2_i(vb[15:11]),
    .id_uses_rs1_i(vb[10]), .id_uses_rs2_i(vb[9]),
    .ex_sel_rd_i(vb[8:4]), .ex_is_load_i(vb[3]),
    .ex_redirect_i(vb[2]), .mem_req_i(vb[1]), .mem_rsp_i(vb[0]),
    .stall_if_o(b_sif), .stall_id_o(b_sid), .stall_ex_o(b_sex),
    .stall_mem_o(b_smem), .flush_if_id_o(b_fif), .flush_id_ex_o(b_fex),
    .stall_cycles_o(b_cnt), .mem_err_o(b_err)
  );

  // ---------------- driver ----------------
  function automatic logic [21:0] mk(input logic rst, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic u1, input logic u2, input logic [4:0] rd,
      input logic ld, input logic rdr, input logic req, input logic rsp);
    return {rst, rs1, rs2, u1, u2, rd, ld, rdr, req, rsp};
  endfunction

  task automatic step_a(input logic [21:0] v, input logic [5:0] ctl,
                        input int cnt, input logic err);
    @(posedge clk);
    #1;
    va = v;
    exp_a_q.push_back({ctl, err, 32'(cnt)});
  endtask

  task automatic step_b(input logic [21:0] v, input logic [5:0] ctl,
                        input int cnt, input logic err);
    @(posedge clk);
    #1;
    vb = v;
    exp_b_q.push_back({ctl, err, 32'(cnt)});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    if (exp_a_q.size() != 0) begin
      e = exp_a_q.pop_front();
      g = {a_sif, a_sid, a_sex, a_smem, a_fif, a_fex, a_err, 32'(a_cnt)};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL a_step%0d got=%h exp=%h", na, g, e);
      end
      na++;
    end
    if (exp_b_q.size() != 0) begin
      e = exp_b_q.pop_front();
      g = {b_sif, b_sid, b_sex, b_smem, b_fif, b_fex, b_err, 32'(b_cnt)};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b_step%0d got=%h exp=%h", nb, g, e);
      end
      nb++;
    end
  end

  // ---------------- stimulus ----------------
  logic [21:0] idle, lu, lu_gone, req, rsp;

  initial begin
    checks = 0;
    errors = 0;
    na = 0;
    nb = 0;
    va = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vb = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu      = mk(1, 1, 5, 1, 1, 5, 1, 0, 0, 0);
    lu_gone = mk(1, 1, 5, 1, 1, 5, 0, 0, 0, 0);
    req     = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rsp     = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    // ---- instance A (LU_STALL=1, MEM_TIMEOUT=4, CNT_W=3) ----
    step_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 0, 0);
    step_a(idle, C_NONE, 0, 0);
    step_a(lu, C_BUB, 0, 0);
    step_a(lu_gone, C_NONE, 1, 0);
    step_a(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0), C_NONE, 1, 0);  // load to x0
    step_a(mk(1, 7, 3, 0, 1, 7, 1, 0, 0, 0), C_NONE, 1, 0);  // rs1 match but unused
    step_a(req, C_MEM, 1, 0);
    step_a(req, C_MEM, 2, 0);
    step_a(req, C_MEM, 3, 0);
    step_a(rsp, C_NONE, 4, 0);
    step_a(rsp, C_NONE, 4, 0);                               // zero-wait access
    step_a(mk(1, 1, 5, 1, 1, 5, 1, 1, 0, 0), C_FL, 4, 0);    // redirect beats lu_hit
    step_a(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_MEM, 4, 0);   // redirect under freeze
    step_a(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1), C_FL, 5, 0);    // flush in rsp cycle
    step_a(idle, C_NONE, 5, 0);
    step_a(mk(1, 1, 5, 1, 1, 5, 1, 0, 1, 0), C_MEM, 5, 0);   // lu_hit under freeze
    step_a(mk(1, 1, 5, 1, 1, 5, 1, 0, 1, 1), C_BUB, 6, 0);   // re-presented on release
    step_a(idle, C_NONE, 7, 0);
    for (int i = 0; i < 5; i++) step_a(req, C_MEM, 7, 0);    // counter saturated at 7
    for (int i = 0; i < 5; i++) step_a(req, C_MEM, 7, 1);    // timeout flagged
    step_a(rsp, C_NONE, 7, 1);
    step_a(idle, C_NONE, 7, 1);
    step_a(req, C_MEM, 7, 1);
    step_a(req, C_MEM, 7, 1);
    step_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_RST, 0, 0);   // reset mid-wait
    step_a(idle, C_NONE, 0, 0);
    step_a(lu, C_BUB, 0, 0);
    step_a(idle, C_NONE, 1, 0);

    // ---- instance B (LU_STALL=2) ----
    step_b(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 0, 0);
    step_b(idle, C_NONE, 0, 0);
    step_b(lu, C_BUB, 0, 0);
    step_b(lu_gone, C_BUB, 1, 0);
    step_b(idle, C_NONE, 2, 0);
    step_b(mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0), C_NONE, 2, 0);
    step_b(lu, C_BUB, 2, 0);
    step_b(mk(1, 1, 5, 1, 1, 5, 0, 1, 0, 0), C_FL, 3, 0);    // abandon LU_STALL
    step_b(idle, C_NONE, 3, 0);
    step_b(lu, C_BUB, 3, 0);
    step_b(req, C_MEM, 4, 0);                                // freeze mid LU_STALL
    step_b(rsp, C_BUB, 5, 0);                                // resume remaining bubble
    step_b(idle, C_NONE, 6, 0);
    step_b(mk(1, 1, 5, 1, 1, 5, 1, 0, 1, 0), C_MEM, 6, 0);
    step_b(mk(1, 1, 5, 1, 1, 5, 1, 0, 1, 1), C_BUB, 7, 0);
    step_b(idle, C_BUB, 8, 0);
    step_b(idle, C_NONE, 9, 0);

    // drain with a bounded wait
    for (int i = 0; i < 5 && (exp_a_q.size() + exp_b_q.size()) != 0; i++) @(posedge clk);
    if ((exp_a_q.size() + exp_b_q.size()) != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_a_q.size() + exp_b_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
